// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO: registered read data with one-cycle latency,
// occupancy-based status flags, programmable almost-full/almost-empty thresholds
// and sticky overflow/underflow error flags.
module fifo_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flag_clr,
  input  logic [ADDR_W:0]   af_level,
  input  logic [ADDR_W:0]   ae_level,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int DEPTH = 1 << ADDR_W;
  // Occupancy value meaning "full": only the wrap bit set.
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  // Storage is never reset; pointers alone decide what is readable.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rv_q, rv_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_acc, wr_acc;

  // Status is derived purely from the pointer registers.
  always_comb begin
    fifo_count        = wptr_q - rptr_q;
    fifo_full         = (fifo_count == FULL_CNT);
    fifo_empty        = (fifo_count == '0);
    fifo_almost_full  = (fifo_count >= af_level);
    fifo_almost_empty = (fifo_count <= ae_level);
  end

  // Accept decisions and next-state for pointers, read data and error flags.
  always_comb begin
    // A read never bypasses a same-cycle write into an empty FIFO.
    rd_acc = rd & ~fifo_empty;
    // A full FIFO still takes a write when a read frees a slot this cycle.
    wr_acc = wr & (~fifo_full | rd_acc);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    dout_d = dout_q;
    rv_d   = 1'b0;
    if (wr_acc) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + PTR_ONE;
      dout_d = mem[rptr_q[ADDR_W-1:0]];
      rv_d   = 1'b1;
    end
    // Set wins over a coincident clear.
    ovf_d = (wr & ~wr_acc) | (ovf_q & ~flag_clr);
    unf_d = (rd & ~rd_acc) | (unf_q & ~flag_clr);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
      rv_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
      rv_q   <= rv_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Storage write; a same-index read in this cycle sees the old word.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr_q[ADDR_W-1:0]] <= data_in;
    end
  end

  assign data_out       = dout_q;
  assign rd_valid       = rv_q;
  assign fifo_overflow  = ovf_q;
  assign fifo_underflow = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: table vectors, directed corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fifo_param;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          wr, rd, flag_clr;
  logic [DW-1:0] data_in;
  logic [AW:0]   af_level, ae_level;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
  logic          fifo_overflow, fifo_underflow;

  fifo_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .data_in(data_in),
    .flag_clr(flag_clr), .af_level(af_level), .ae_level(ae_level),
    .data_out(data_out), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_almost_full(fifo_almost_full), .fifo_almost_empty(fifo_almost_empty),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a queue of stored words plus the output registers.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_rv, m_ovf, m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ".count"}, 32'(fifo_count), 32'(sz));
    chk({tag, ".full"}, 32'(fifo_full), 32'(sz == DEPTH));
    chk({tag, ".empty"}, 32'(fifo_empty), 32'(sz == 0));
    chk({tag, ".afull"}, 32'(fifo_almost_full), 32'(sz >= int'(af_level)));
    chk({tag, ".aempty"}, 32'(fifo_almost_empty), 32'(sz <= int'(ae_level)));
    chk({tag, ".dout"}, 32'(data_out), 32'(m_dout));
    chk({tag, ".rv"}, 32'(rd_valid), 32'(m_rv));
    chk({tag, ".ovf"}, 32'(fifo_overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(fifo_underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_rv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock of traffic: update the model from pre-edge state, clock, compare.
  task automatic step(input string tag, input logic w, input logic r,
                      input logic [DW-1:0] d, input logic c);
    logic racc, wacc;
    wr = w; rd = r; data_in = d; flag_clr = c;
    racc = r && (mq.size() != 0);
    wacc = w && ((mq.size() != DEPTH) || racc);
    m_ovf = (w && !wacc) || (m_ovf && !c);
    m_unf = (r && !racc) || (m_unf && !c);
    if (racc) begin
      m_dout = mq.pop_front();
      m_rv   = 1'b1;
    end else begin
      m_rv = 1'b0;
    end
    if (wacc) mq.push_back(d);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; flag_clr = 1'b0;
    compare_all(tag);
    $display("%s wr=%0b rd=%0b din=%02h clr=%0b -> cnt=%0d dout=%02h rv=%0b ovf=%0b unf=%0b",
             tag, w, r, d, c, fifo_count, data_out, rd_valid, fifo_overflow, fifo_underflow);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; flag_clr = 1'b0; data_in = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    compare_all({tag, ".rst"});
    rst_n = 1'b1;
    $display("%s reset applied", tag);
  endtask

  task automatic fill(input string tag, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, base + DW'(i), 1'b0);
  endtask

  typedef struct {
    logic          w, r, c;
    logic [DW-1:0] d;
    int            cnt;
    logic [DW-1:0] dout;
    logic          rv, unf;
  } vec_t;

  vec_t vt[9];

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; flag_clr = 1'b0; data_in = '0;
    af_level = 5'd16; ae_level = 5'd0;
    model_reset();

    // ---- table-driven vectors (expected values hand-derived) ----
    vt[0] = '{w:0, r:1, c:0, d:8'h00, cnt:0, dout:8'h00, rv:0, unf:1};
    vt[1] = '{w:1, r:0, c:0, d:8'h11, cnt:1, dout:8'h00, rv:0, unf:1};
    vt[2] = '{w:1, r:0, c:1, d:8'h22, cnt:2, dout:8'h00, rv:0, unf:0};
    vt[3] = '{w:1, r:1, c:0, d:8'h33, cnt:2, dout:8'h11, rv:1, unf:0};
    vt[4] = '{w:0, r:1, c:0, d:8'h00, cnt:1, dout:8'h22, rv:1, unf:0};
    vt[5] = '{w:0, r:0, c:0, d:8'h00, cnt:1, dout:8'h22, rv:0, unf:0};
    vt[6] = '{w:0, r:1, c:0, d:8'h00, cnt:0, dout:8'h33, rv:1, unf:0};
    vt[7] = '{w:1, r:1, c:0, d:8'h44, cnt:1, dout:8'h33, rv:0, unf:1};
    vt[8] = '{w:0, r:1, c:1, d:8'h00, cnt:0, dout:8'h44, rv:1, unf:0};
    do_reset("tbl");
    for (int i = 0; i < 9; i++) begin
      step($sformatf("tbl%0d", i), vt[i].w, vt[i].r, vt[i].d, vt[i].c);
      chk($sformatf("tbl%0d.cnt", i), 32'(fifo_count), 32'(vt[i].cnt));
      chk($sformatf("tbl%0d.dout", i), 32'(data_out), 32'(vt[i].dout));
      chk($sformatf("tbl%0d.rv", i), 32'(rd_valid), 32'(vt[i].rv));
      chk($sformatf("tbl%0d.unf", i), 32'(fifo_underflow), 32'(vt[i].unf));
    end

    // ---- fill to full, then overflow ----
    do_reset("full");
    fill("full", 16, 8'h01);
    chk("full.full", 32'(fifo_full), 32'd1);
    chk("full.count", 32'(fifo_count), 32'd16);
    step("full17", 1'b1, 1'b0, 8'hEE, 1'b0);
    chk("full17.ovf", 32'(fifo_overflow), 32'd1);
    chk("full17.count", 32'(fifo_count), 32'd16);

    // ---- drain 16 in order, then underflow ----
    for (int i = 0; i < 16; i++) begin
      step("drain", 1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain.dout", 32'(data_out), 32'(i + 1));
      chk("drain.rv", 32'(rd_valid), 32'd1);
    end
    chk("drain.empty", 32'(fifo_empty), 32'd1);
    step("drain_x", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("drain_x.unf", 32'(fifo_underflow), 32'd1);
    chk("drain_x.dout", 32'(data_out), 32'h10);
    chk("drain_x.rv", 32'(rd_valid), 32'd0);

    // ---- simultaneous read+write while full ----
    do_reset("rw");
    fill("rw", 16, 8'h01);
    step("rw_full", 1'b1, 1'b1, 8'hAA, 1'b0);
    chk("rw_full.dout", 32'(data_out), 32'h01);
    chk("rw_full.count", 32'(fifo_count), 32'd16);
    chk("rw_full.ovf", 32'(fifo_overflow), 32'd0);
    for (int i = 0; i < 16; i++) step("rw_drain", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("rw_drain.last", 32'(data_out), 32'hAA);

    // ---- almost-full / almost-empty thresholds ----
    af_level = 5'd12; ae_level = 5'd3;
    do_reset("thr");
    for (int i = 1; i <= 12; i++) begin
      step("thr_w", 1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
      chk("thr_w.afull", 32'(fifo_almost_full), 32'(i == 12));
    end
    for (int i = 11; i >= 3; i--) begin
      step("thr_r", 1'b0, 1'b1, 8'h00, 1'b0);
      chk("thr_r.aempty", 32'(fifo_almost_empty), 32'(i == 3));
    end

    // ---- sticky error flags and clear priority ----
    af_level = 5'd16; ae_level = 5'd0;
    do_reset("flg");
    step("flg_unf", 1'b0, 1'b1, 8'h00, 1'b0);
    fill("flg", 16, 8'h80);
    step("flg_ovf", 1'b1, 1'b0, 8'hFF, 1'b0);
    chk("flg.ovf_set", 32'(fifo_overflow), 32'd1);
    chk("flg.unf_set", 32'(fifo_underflow), 32'd1);
    step("flg_clr", 1'b0, 1'b0, 8'h00, 1'b1);
    chk("flg_clr.ovf", 32'(fifo_overflow), 32'd0);
    chk("flg_clr.unf", 32'(fifo_underflow), 32'd0);
    step("flg_both", 1'b1, 1'b0, 8'hFE, 1'b1);
    chk("flg_both.ovf", 32'(fifo_overflow), 32'd1);

    // ---- asynchronous reset mid-stream ----
    do_reset("ar");
    fill("ar", 5, 8'h21);
    step("ar_rd", 1'b0, 1'b1, 8'h00, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar.count", 32'(fifo_count), 32'd0);
    chk("ar.empty", 32'(fifo_empty), 32'd1);
    chk("ar.dout", 32'(data_out), 32'd0);
    $display("ar async reset asserted mid-cycle");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("ar_w", 1'b1, 1'b0, 8'h5A, 1'b0);
    step("ar_w", 1'b1, 1'b0, 8'h5B, 1'b0);
    step("ar_r", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("ar_r.first", 32'(data_out), 32'h5A);
    step("ar_r", 1'b0, 1'b1, 8'h00, 1'b0);
    step("ar_r", 1'b0, 1'b1, 8'h00, 1'b0);
    chk("ar_r.stale", 32'(data_out), 32'h5B);

    // ---- randomized traffic against the model ----
    do_reset("rnd");
    begin
      int wbias;
      wbias = 50;
      for (int i = 0; i < 1200; i++) begin
        if (i % 150 == 0) begin
          wbias = (i / 150) % 2 == 0 ? 75 : 25;
          af_level = 5'($urandom_range(0, DEPTH));
          ae_level = 5'($urandom_range(0, DEPTH));
        end
        step("rnd",
             1'($urandom_range(0, 99) < wbias),
             1'($urandom_range(0, 99) >= wbias - 10),
             8'($urandom),
             1'($urandom_range(0, 19) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
